// File: rtl/booth_seq_mult.sv
`default_nettype none
// ============================================================================
//  Module   : booth_seq_mult
//  Brief    : Sequential radix-2 Booth multiplier, signed or unsigned operands,
//             one Booth step per clock, ready/valid result handshake.
//  Revision : 1.0  initial release
// ============================================================================
module booth_seq_mult #(
    parameter int DATA_WIDTH = 4,
    parameter int CNT_WIDTH  = 3
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_start,
    input  logic                    i_signed,
    input  logic [DATA_WIDTH-1:0]   i_multiplicand,
    input  logic [DATA_WIDTH-1:0]   i_multiplier,
    input  logic                    i_out_ready,
    output logic                    o_ready,
    output logic                    o_busy,
    output logic                    o_valid,
    output logic [2*DATA_WIDTH-1:0] o_product
);

    localparam int N = DATA_WIDTH;

    // Counter value on which the (N+1)th and final Booth step is taken.
    localparam logic [CNT_WIDTH-1:0] c_LAST_STEP = CNT_WIDTH'(DATA_WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // Datapath: operands are carried one bit wider than N so that unsigned
    // values become non-negative signed values and one Booth engine serves
    // both modes. A is one bit wider again so A +/- M can never overflow.
    logic [N+1:0]         r_a;
    logic [N:0]           r_q;
    logic [N:0]           r_m;
    logic                 r_q_1;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [2*N-1:0]       r_product;

    logic                 w_accept;
    logic                 w_last_step;
    logic [N:0]           w_m_in;
    logic [N:0]           w_q_in;
    logic [N+1:0]         w_m_ext;
    logic [N+1:0]         w_a_sum;
    logic [N+1:0]         w_a_shift;
    logic [N:0]           w_q_shift;

    assign w_last_step = (r_cnt == c_LAST_STEP);

    // Operand extension selected by the mode bit captured with the start.
    assign w_m_in  = i_signed ? {i_multiplicand[N-1], i_multiplicand} : {1'b0, i_multiplicand};
    assign w_q_in  = i_signed ? {i_multiplier[N-1],   i_multiplier}   : {1'b0, i_multiplier};
    assign w_m_ext = {r_m[N], r_m};

    // Booth add/subtract decision on {Q0, Q-1}.
    always_comb begin
        w_a_sum = r_a;
        case ({r_q[0], r_q_1})
            2'b01:   w_a_sum = r_a + w_m_ext;
            2'b10:   w_a_sum = r_a - w_m_ext;
            default: w_a_sum = r_a;
        endcase
    end

    // Arithmetic shift right of {A, Q, Q-1} by one bit.
    assign w_a_shift = {w_a_sum[N+1], w_a_sum[N+1:1]};
    assign w_q_shift = {w_a_sum[0], r_q[N:1]};

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        o_ready      = 1'b0;
        o_busy       = 1'b0;
        o_valid      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                o_ready = 1'b1;
                if (i_start) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                o_busy = 1'b1;
                if (w_last_step) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                o_valid = 1'b1;
                o_ready = i_out_ready;
                if (i_out_ready) begin
                    if (i_start) begin
                        w_accept     = 1'b1;
                        w_state_next = ST_RUN;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Operand capture, Booth iteration and result capture.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_a       <= '0;
            r_q       <= '0;
            r_m       <= '0;
            r_q_1     <= 1'b0;
            r_cnt     <= '0;
            r_product <= '0;
        end else if (w_accept) begin
            r_a   <= '0;
            r_q   <= w_q_in;
            r_m   <= w_m_in;
            r_q_1 <= 1'b0;
            r_cnt <= '0;
        end else if (r_state == ST_RUN) begin
            r_a   <= w_a_shift;
            r_q   <= w_q_shift;
            r_q_1 <= r_q[0];
            r_cnt <= r_cnt + 1'b1;
            // The low 2N bits of the final {A,Q} are the exact product.
            if (w_last_step) begin
                r_product <= {w_a_shift[N-2:0], w_q_shift};
            end
        end
    end

    assign o_product = r_product;

endmodule
`default_nettype wire
